// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - EX-stage resolver for fetch-side 2-bit branch predictions
//
// Holds an in-order queue of predictions captured at fetch and compares each
// against the outcome computed in EX. It trains the predictor through
// history/hist_valid. On a mispredict it issues a redirect and a timed flush.
//
// Optional feature: define BRES_STATS_EN to add the stat_br/stat_mis counters.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   if_fire/if_branch fetch accepted an instruction / it is a conditional branch
//   if_taken[1:0]     predictor state, predicted taken = if_taken[1]
//   if_pc[31:0]       branch PC captured with the prediction
//   ex_valid/ex_branch EX holds a valid instruction / it is a conditional branch
//   ex_pc[31:0]       PC of the EX instruction
//   ex_cond           actual outcome (1 = taken)
//   ex_target[31:0]   computed taken target
//   history           last resolved outcome, held between resolutions
//   hist_valid        one-cycle pulse when history is updated
//   redirect          one-cycle pulse on mispredict
//   redirect_pc[31:0] corrected fetch PC, held after the redirect
//   flush             squash younger instructions
//   q_full            prediction queue full, fetch must stall branches
//   q_err             sticky protocol error
//   stat_br/stat_mis  resolution / mispredict counters (BRES_STATS_EN only)
module branch_resolver #(
    parameter int DEPTH     = 4,
    parameter int FLUSH_LEN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_fire,
    input  logic        if_branch,
    input  logic [1:0]  if_taken,
    input  logic [31:0] if_pc,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_cond,
    input  logic [31:0] ex_target,
    output logic        history,
    output logic        hist_valid,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        q_full,
    output logic        q_err
`ifdef BRES_STATS_EN
    ,
    output logic [31:0] stat_br,
    output logic [31:0] stat_mis
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t        state, state_next;
    logic [FW-1:0] fcnt, fcnt_next;

    logic [31:0]   pc_mem   [DEPTH];
    logic          pred_mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic run, push_req, pop_req, q_empty, pop_ok, push_ok, push_drop;
    logic head_pred, pc_mismatch, mispredict, set_err;

    // Only the taken/not-taken half of the predictor state matters here.
    logic unused_taken_lsb;
    assign unused_taken_lsb = if_taken[0];

    assign run      = (state == ST_RUN);
    assign q_empty  = (count == '0);
    assign q_full   = (count == CW'(DEPTH));
    assign flush    = (state == ST_FLUSH);

    assign push_req = run && if_fire && if_branch;
    assign pop_req  = run && ex_valid && ex_branch;
    assign pop_ok   = pop_req && !q_empty;
    // A pop in the same cycle frees the slot, so a push while full still fits.
    assign push_ok   = push_req && (!q_full || pop_ok);
    assign push_drop = push_req && q_full && !pop_ok;

    // An EX branch with nothing queued resolves as predicted not-taken.
    assign head_pred   = pop_ok ? pred_mem[rd_ptr] : 1'b0;
    assign pc_mismatch = pop_ok && (pc_mem[rd_ptr] != ex_pc);
    assign mispredict  = pop_req && (head_pred ^ ex_cond);
    assign set_err     = push_drop || (pop_req && q_empty) || pc_mismatch;

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        case (state)
            ST_RUN: begin
                if (mispredict) begin
                    state_next = ST_FLUSH;
                    fcnt_next  = FW'(FLUSH_LEN - 1);
                end
            end
            ST_FLUSH: begin
                if (fcnt == '0) begin
                    state_next = ST_RUN;
                end else begin
                    fcnt_next = fcnt - FW'(1);
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[wr_ptr]   <= if_pc;
            pred_mem[wr_ptr] <= if_taken[1];
        end
    end

    // A mispredict empties the queue: every queued entry is younger and squashed.
    always_ff @(posedge clk) begin
        if (rst || mispredict) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            history     <= 1'b0;
            hist_valid  <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            q_err       <= 1'b0;
        end else begin
            hist_valid <= pop_req;
            redirect   <= mispredict;
            if (pop_req)    history     <= ex_cond;
            if (mispredict) redirect_pc <= ex_cond ? ex_target : ex_pc + 32'd4;
            if (set_err)    q_err       <= 1'b1;
        end
    end

`ifdef BRES_STATS_EN
    // Counters step on the same edge that raises hist_valid/redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br  <= '0;
            stat_mis <= '0;
        end else begin
            if (pop_req)    stat_br  <= stat_br + 32'd1;
            if (mispredict) stat_mis <= stat_mis + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - self-checking bench for branch_resolver
module tb_branch_resolver;

    localparam int DEPTH     = 4;
    localparam int FLUSH_LEN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_fire, if_branch;
    logic [1:0]  if_taken;
    logic [31:0] if_pc;
    logic        ex_valid, ex_branch, ex_cond;
    logic [31:0] ex_pc, ex_target;
    logic        history, hist_valid, redirect, flush, q_full, q_err;
    logic [31:0] redirect_pc;
`ifdef BRES_STATS_EN
    logic [31:0] stat_br, stat_mis;
`endif

    always #5 clk = ~clk;

    branch_resolver #(.DEPTH(DEPTH), .FLUSH_LEN(FLUSH_LEN)) dut (
        .clk(clk), .rst(rst),
        .if_fire(if_fire), .if_branch(if_branch), .if_taken(if_taken), .if_pc(if_pc),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pc(ex_pc),
        .ex_cond(ex_cond), .ex_target(ex_target),
        .history(history), .hist_valid(hist_valid), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .q_full(q_full), .q_err(q_err)
`ifdef BRES_STATS_EN
        , .stat_br(stat_br), .stat_mis(stat_mis)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        q[$];
    logic        m_hist, m_hv, m_redir, m_err;
    logic [31:0] m_rpc, m_br, m_mis;
    int          m_fl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: outcome of one clock edge given the inputs presented to it.
    task automatic model_edge();
        int   sz;
        logic pushr, popr, pred, popped;
        ent_t e;
        if (rst) begin
            q.delete();
            m_hist = 0; m_hv = 0; m_redir = 0; m_err = 0;
            m_rpc = 0; m_br = 0; m_mis = 0; m_fl = 0;
        end else if (m_fl > 0) begin
            m_fl--;
            m_hv = 0;
            m_redir = 0;
        end else begin
            sz     = q.size();
            pushr  = if_fire && if_branch;
            popr   = ex_valid && ex_branch;
            pred   = 0;
            popped = 0;
            m_hv   = popr;
            m_redir = 0;
            if (popr) begin
                if (sz == 0) m_err = 1;
                else begin
                    pred = q[0].pred;
                    if (q[0].pc != ex_pc) m_err = 1;
                end
                m_hist = ex_cond;
                m_br++;
            end
            if (popr && (pred != ex_cond)) begin
                m_redir = 1;
                m_mis++;
                m_rpc = ex_cond ? ex_target : ex_pc + 32'd4;
                m_fl = FLUSH_LEN;
                q.delete();
            end else begin
                if (popr && sz > 0) begin
                    void'(q.pop_front());
                    popped = 1;
                end
                if (pushr) begin
                    if (sz < DEPTH || popped) begin
                        e.pc = if_pc;
                        e.pred = if_taken[1];
                        q.push_back(e);
                    end else m_err = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        check("history",     history,     m_hist);
        check("hist_valid",  hist_valid,  m_hv);
        check("redirect",    redirect,    m_redir);
        check("redirect_pc", redirect_pc, m_rpc);
        check("flush",       flush,       m_fl > 0);
        check("q_full",      q_full,      q.size() == DEPTH);
        check("q_err",       q_err,       m_err);
`ifdef BRES_STATS_EN
        check("stat_br",  stat_br,  m_br);
        check("stat_mis", stat_mis, m_mis);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic clr();
        rst = 0; if_fire = 0; if_branch = 0; if_taken = 0; if_pc = 0;
        ex_valid = 0; ex_branch = 0; ex_pc = 0; ex_cond = 0; ex_target = 0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic [1:0] tk);
        if_fire = 1; if_branch = 1; if_pc = pc; if_taken = tk;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic c, input logic [31:0] tgt);
        ex_valid = 1; ex_branch = 1; ex_pc = pc; ex_cond = c; ex_target = tgt;
    endtask

    initial begin
        clr();
        rst = 1;
        tick();
        check("rst_flush", flush, 0);
        check("rst_q_full", q_full, 0);
        check("rst_q_err", q_err, 0);
        clr();

        // Correctly predicted taken branch.
        set_push(32'h100, 2'b11); tick(); clr();
        set_ex(32'h100, 1, 32'h180); tick(); clr();
        check("t1_hist", history, 1);
        check("t1_hv", hist_valid, 1);
        check("t1_redirect", redirect, 0);
        tick();
        check("t1_hv_pulse", hist_valid, 0);

        // Predicted not-taken, actually taken.
        set_push(32'h200, 2'b01); tick(); clr();
        set_ex(32'h200, 1, 32'h240); tick(); clr();
        check("t2_redirect", redirect, 1);
        check("t2_rpc", redirect_pc, 32'h240);
        check("t2_flush1", flush, 1);
        tick();
        check("t2_flush2", flush, 1);
        check("t2_rpc_held", redirect_pc, 32'h240);
        tick();
        check("t2_flush_end", flush, 0);

        // Predicted taken, actually not-taken; pushes during flush ignored.
        set_push(32'h300, 2'b10); tick(); clr();
        set_ex(32'h300, 0, 32'h380); tick(); clr();
        check("t3_rpc", redirect_pc, 32'h304);
        set_push(32'h999, 2'b11); tick(); tick(); clr();
        check("t3_q_err", q_err, 0);
        check("t3_flush_end", flush, 0);
        tick();

        // Fill, overflow, and push+pop while full.
        set_push(32'h10, 2'b11); tick();
        set_push(32'h20, 2'b11); tick();
        set_push(32'h30, 2'b11); tick();
        set_push(32'h40, 2'b11); tick(); clr();
        check("t4_full", q_full, 1);
        check("t4_no_err", q_err, 0);
        set_push(32'h50, 2'b11); tick(); clr();
        check("t4_drop_err", q_err, 1);
        set_push(32'h60, 2'b11); set_ex(32'h10, 1, 32'h0); tick(); clr();
        check("t4_full_pp", q_full, 1);
        check("t4_pp_redirect", redirect, 0);
        set_ex(32'h20, 1, 0); tick();
        set_ex(32'h30, 1, 0); tick();
        set_ex(32'h40, 1, 0); tick();
        set_ex(32'h60, 1, 0); tick(); clr();
        check("t4_drained_redirect", redirect, 0);
        tick();

        // EX branch with empty queue, then reset mid-flush.
        rst = 1; tick(); clr();
        set_ex(32'h500, 1, 32'h580); tick(); clr();
        check("t5_redirect", redirect, 1);
        check("t5_rpc", redirect_pc, 32'h580);
        check("t5_q_err", q_err, 1);
        check("t5_flush", flush, 1);
        rst = 1; tick(); clr();
        check("t5_rst_flush", flush, 0);
        check("t5_rst_q_err", q_err, 0);

        // Three resolutions, one mispredict.
        set_push(32'hA00, 2'b11); tick(); clr();
        set_ex(32'hA00, 1, 0); tick(); clr();
        set_push(32'hA10, 2'b11); tick(); clr();
        set_ex(32'hA10, 1, 0); tick(); clr();
        set_push(32'hA20, 2'b00); tick(); clr();
        set_ex(32'hA20, 1, 32'hB00); tick(); clr();
        tick(); tick();
`ifdef BRES_STATS_EN
        check("t6_stat_br", stat_br, 3);
        check("t6_stat_mis", stat_mis, 1);
`endif
        check("t6_rpc", redirect_pc, 32'hB00);

        // Randomized traffic, including PC wrap on the not-taken path.
        for (int i = 0; i < 600; i++) begin
            clr();
            rst       = ($urandom % 80) == 0;
            if_fire   = $urandom % 2;
            if_branch = ($urandom % 3) != 0;
            if_taken  = 2'($urandom);
            if_pc     = ($urandom % 16 == 0) ? 32'hFFFF_FFFC : 32'h1000 + 32'(($urandom % 16) << 2);
            ex_valid  = $urandom % 2;
            ex_branch = ($urandom % 3) == 0;
            ex_cond   = $urandom % 2;
            ex_target = $urandom;
            if (q.size() > 0 && ($urandom % 8) != 0) ex_pc = q[0].pc;
            else ex_pc = 32'h1000 + 32'(($urandom % 16) << 2);
            tick();
        end
        clr();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
